// File: rtl/filter_result_capture_pkg.sv
// Shared definitions for the filtered-sample capture block: controller state
// encodings and default sizing constants.
package filter_result_capture_pkg;

    localparam logic [0:0] ST_CAPTURE = 1'b0;
    localparam logic [0:0] ST_DONE    = 1'b1;

    localparam int DEF_DATA_BITS = 8;
    localparam int DEF_ADDR_BITS = 8;
    localparam int DEF_DEPTH     = 255;
    localparam int DEF_WARMUP    = 5;

    // Bits needed to count 0..warmup inclusive (at least one bit).
    function automatic int warm_bits(input int warmup);
        return (warmup < 1) ? 1 : $clog2(warmup + 1);
    endfunction

endpackage

// File: rtl/filter_result_capture_if.sv
// Sample-stream, browse-button and display bundle of filter_result_capture.
interface filter_result_capture_if
    import filter_result_capture_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int ADDR_BITS = DEF_ADDR_BITS
);
    logic                 in_valid;
    logic [DATA_BITS-1:0] in_data;
    logic                 step_up;
    logic                 step_down;
    logic                 done;
    logic                 overflow;
    logic [ADDR_BITS-1:0] count;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [DATA_BITS-1:0] rd_data;

    modport master (
        output in_valid, in_data, step_up, step_down,
        input  done, overflow, count, rd_addr, rd_data
    );

    modport slave (
        input  in_valid, in_data, step_up, step_down,
        output done, overflow, count, rd_addr, rd_data
    );

endinterface

// File: rtl/filter_result_capture_ram.sv
// Capture buffer: one write port and one registered read port on a single clock.
module capture_dp_ram
    import filter_result_capture_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    logic [DATA_BITS-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset so it maps onto block RAM; only the read register resets.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_data <= '0;
        else      rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/filter_result_capture.sv
// Captures the filtered stream after warm-up, stops at end-of-stream or full,
// then lets debounced up/down buttons browse the stored samples.
module filter_result_capture
    import filter_result_capture_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int ADDR_BITS = DEF_ADDR_BITS,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int WARMUP    = DEF_WARMUP
) (
    input logic                    clk,
    input logic                    rst,
    filter_result_capture_if.slave bus
);

    localparam int                   WB        = warm_bits(WARMUP);
    localparam logic [WB-1:0]        WARM_MAX  = WB'(WARMUP);
    localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

    logic [0:0]           state;
    logic [WB-1:0]        warm;
    logic [ADDR_BITS-1:0] count;
    logic [ADDR_BITS-1:0] rd_addr;
    logic                 overflow;
    logic                 valid_q, up_q, down_q;
    logic                 valid_fall, up_edge, down_edge, wr_en;

    assign valid_fall = valid_q & ~bus.in_valid;
    assign up_edge    = bus.step_up & ~up_q;
    assign down_edge  = bus.step_down & ~down_q;
    assign wr_en      = (state == ST_CAPTURE) && bus.in_valid && (warm == WARM_MAX);

    // Edge history resets with everything else, so a stream starting right
    // after reset is never mistaken for the end of the previous one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_CAPTURE;
            warm     <= '0;
            count    <= '0;
            rd_addr  <= '0;
            overflow <= 1'b0;
            valid_q  <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
        end else begin
            valid_q <= bus.in_valid;
            up_q    <= bus.step_up;
            down_q  <= bus.step_down;
            if (state == ST_CAPTURE) begin
                if (bus.in_valid) begin
                    if (warm != WARM_MAX) begin
                        warm <= warm + 1'b1;
                    end else begin
                        count <= count + 1'b1;
                        if (count == LAST_ADDR) state <= ST_DONE;
                    end
                end else if (valid_fall) begin
                    state <= ST_DONE;
                end
            end else begin
                if (bus.in_valid) overflow <= 1'b1;
                // Browse wraps against the stored count, not the address space.
                if (count != '0 && up_edge != down_edge) begin
                    if (up_edge) rd_addr <= (rd_addr == count - 1'b1) ? '0 : rd_addr + 1'b1;
                    else         rd_addr <= (rd_addr == '0) ? count - 1'b1 : rd_addr - 1'b1;
                end
            end
        end
    end

    capture_dp_ram #(
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (ADDR_BITS),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (count),
        .wr_data (bus.in_data),
        .rd_addr (rd_addr),
        .rd_data (bus.rd_data)
    );

    assign bus.done     = (state == ST_DONE);
    assign bus.overflow = overflow;
    assign bus.count    = count;
    assign bus.rd_addr  = rd_addr;

endmodule

// File: tb/tb_filter_result_capture.sv
// Directed-plus-random bench for filter_result_capture against a stream-level
// reference model (expected memory is a slice of the sent sample queue).
module tb_filter_result_capture;

    localparam int DATA_BITS = 8;
    localparam int ADDR_BITS = 8;
    localparam int DEPTH     = 255;
    localparam int WARMUP    = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    filter_result_capture_if #(.DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS)) bus ();

    filter_result_capture #(
        .DATA_BITS (DATA_BITS),
        .ADDR_BITS (ADDR_BITS),
        .DEPTH     (DEPTH),
        .WARMUP    (WARMUP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int stream[$];
    int exp_mem[DEPTH];
    int exp_count;
    int exp_ovf;
    int m_addr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_overflow"}, 32'(bus.overflow), 0);
        check({tag, "_count"}, 32'(bus.count), 0);
        check({tag, "_rd_addr"}, 32'(bus.rd_addr), 0);
        check({tag, "_rd_data"}, 32'(bus.rd_data), 0);
    endtask

    task automatic assert_reset(input string tag);
        bus.in_valid = 1'b0;
        bus.step_up = 1'b0;
        bus.step_down = 1'b0;
        #1;
        check_all_zero(tag);
    endtask

    task automatic release_reset();
        tick();
        tick();
        rst = 1'b1;
        stream.delete();
        m_addr = 0;
        tick();
        tick();
        check("post_reset_done", 32'(bus.done), 0);
        check("post_reset_count", 32'(bus.count), 0);
    endtask

    // Expected capture derived from the whole sent stream.
    task automatic build_model();
        int n;
        n = stream.size();
        exp_count = (n > WARMUP) ? n - WARMUP : 0;
        if (exp_count > DEPTH) exp_count = DEPTH;
        exp_ovf = (n > WARMUP + DEPTH) ? 1 : 0;
        for (int j = 0; j < exp_count; j++) exp_mem[j] = stream[WARMUP + j];
    endtask

    task automatic send_stream(input int n, input bit sequential);
        int d;
        for (int i = 0; i < n; i++) begin
            d = sequential ? (i + 1) : int'($urandom_range(0, 255));
            bus.in_valid = 1'b1;
            bus.in_data = 8'(d);
            stream.push_back(d);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        build_model();
    endtask

    task automatic check_capture(input string tag);
        check({tag, "_done"}, 32'(bus.done), 1);
        check({tag, "_count"}, 32'(bus.count), 32'(exp_count));
        check({tag, "_overflow"}, 32'(bus.overflow), 32'(exp_ovf));
    endtask

    task automatic check_browse(input string tag);
        check({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'(m_addr));
        if (exp_count > 0) check({tag, "_rd_data"}, 32'(bus.rd_data), 32'(exp_mem[m_addr]));
    endtask

    task automatic model_move(input bit up, input bit down);
        if (exp_count > 0 && up != down) begin
            if (up) m_addr = (m_addr + 1) % exp_count;
            else    m_addr = (m_addr + exp_count - 1) % exp_count;
        end
    endtask

    task automatic press(input string tag, input bit up, input bit down);
        bus.step_up = up;
        bus.step_down = down;
        tick();
        bus.step_up = 1'b0;
        bus.step_down = 1'b0;
        tick();
        model_move(up, down);
        check_browse(tag);
    endtask

    task automatic walk(input string tag);
        for (int i = 0; i < exp_count; i++) press(tag, 1'b1, 1'b0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.step_up = 1'b0;
        bus.step_down = 1'b0;

        // T1: 12 samples 1..12, warm-up drops the first five
        assert_reset("rst0");
        release_reset();
        send_stream(12, 1'b1);
        check_capture("t1");
        check("t1_count_lit", 32'(bus.count), 7);
        check_browse("t1_addr0");
        check("t1_mem0_lit", 32'(bus.rd_data), 6);
        walk("t1_walk");

        // T3: wrap both ways at count-1 / 0
        press("t3_down_wrap", 1'b0, 1'b1);
        check("t3_addr6_lit", 32'(bus.rd_addr), 6);
        press("t3_up_wrap", 1'b1, 1'b0);
        check("t3_addr0_lit", 32'(bus.rd_addr), 0);
        press("t3_down_again", 1'b0, 1'b1);

        // T4: simultaneous edges cancel; a held level moves once
        press("t4_both", 1'b1, 1'b1);
        bus.step_up = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.step_up = 1'b0;
        tick();
        model_move(1'b1, 1'b0);
        check_browse("t4_hold");

        for (int i = 0; i < 30; i++) begin
            int op;
            op = int'($urandom_range(0, 3));
            press("rnd_browse", op == 0 || op == 2, op == 1 || op == 2);
        end

        // Valid data after done sets the sticky overflow, nothing is stored
        bus.in_valid = 1'b1;
        bus.in_data = 8'hA5;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        check("t1_ovf_set", 32'(bus.overflow), 1);
        check("t1_ovf_count", 32'(bus.count), 7);
        check("t1_ovf_done", 32'(bus.done), 1);

        // T5: stream shorter than warm-up
        rst = 1'b0;
        assert_reset("rst5");
        release_reset();
        send_stream(3, 1'b0);
        check_capture("t5");
        press("t5_up", 1'b1, 1'b0);
        press("t5_down", 1'b0, 1'b1);

        // T2: 300 samples fill memory then overflow
        rst = 1'b0;
        assert_reset("rst2");
        release_reset();
        send_stream(300, 1'b0);
        check_capture("t2");
        check_browse("t2_addr0");
        press("t2_mem254", 1'b0, 1'b1);
        check("t2_mem254_sample260", 32'(bus.rd_data), 32'(stream[259]));
        press("t2_back0", 1'b1, 1'b0);
        walk("t2_walk");

        // T6: reset in the middle of a capture
        rst = 1'b0;
        assert_reset("rst6a");
        release_reset();
        for (int i = 0; i < 39; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'($urandom_range(0, 255));
            tick();
        end
        check("t6_mid_count", 32'(bus.count), 34);
        check("t6_mid_done", 32'(bus.done), 0);
        bus.in_valid = 1'b1;
        bus.in_data = 8'h3C;
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("t6_async");
        assert_reset("t6_hold");
        release_reset();
        send_stream(20, 1'b0);
        check_capture("t6_restart");
        check_browse("t6_addr0");
        walk("t6_walk");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
